// File: rtl/snapshot_ctrl_pkg.sv
// Shared types and helpers for the snapshot capture sequencer:
// FSM state encoding, trigger-mode codes and capture-length computation.
package snapshot_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_TRIG    = 3'd2,
    ST_CAPTURE = 3'd3,
    ST_DONE    = 3'd4,
    ST_HOLDOFF = 3'd5
  } state_e;

  localparam logic [1:0] TRIG_MODE_IMM = 2'd0;
  localparam logic [1:0] TRIG_MODE_EXT = 2'd1;

  // Number of DWIDTH-bit beats needed to fill one snapshot buffer.
  function automatic int cap_beats_f(input int mem_size_bytes, input int dwidth);
    return mem_size_bytes / (dwidth / 8);
  endfunction

endpackage

// File: rtl/snapshot_capture_sequencer.sv
// Arms, triggers and times fixed-length captures across NCH snapshot channels,
// with optional auto-repeat after a holdoff; all outputs are registered.
module snapshot_capture_sequencer
  import snapshot_ctrl_pkg::*;
#(
  parameter int NCH            = 4,
  parameter int DWIDTH         = 128,
  parameter int MEM_SIZE_BYTES = 131072,
  parameter int TRIG_HOLD      = 4,
  parameter int SYNC_LAT       = 3,
  parameter int CNT_W          = 32
) (
  input  logic             axis_clk,
  input  logic             axis_rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [1:0]       trig_mode,
  input  logic [NCH-1:0]   chan_mask,
  input  logic             ext_trig,
  input  logic [CNT_W-1:0] timeout_cyc,
  input  logic             repeat_en,
  input  logic [CNT_W-1:0] holdoff_cyc,
  output logic [NCH-1:0]   trig_cap,
  output logic             busy,
  output logic             armed,
  output logic             done,
  output logic             done_pulse,
  output logic             timed_out,
  output logic [15:0]      cap_count,
  output logic [2:0]       state_mon
);

  localparam int CAP_BEATS = cap_beats_f(MEM_SIZE_BYTES, DWIDTH);
  localparam int CYC_W     = $clog2(SYNC_LAT + CAP_BEATS + TRIG_HOLD);
  localparam logic [CYC_W-1:0] TRIG_LAST = CYC_W'(TRIG_HOLD - 1);
  localparam logic [CYC_W-1:0] CAP_LAST  = CYC_W'(SYNC_LAT + CAP_BEATS - 1);

  state_e           state_r;
  state_e           state_nxt_s;
  logic [NCH-1:0]   mask_r;
  logic [CYC_W-1:0] cyc_r;
  logic [CNT_W-1:0] cnt_r;
  logic             ext_prev_r;

  logic             ext_edge_s;
  logic             tmo_hit_s;
  logic             hold_hit_s;
  logic             trig_now_s;
  logic             latch_mask_s;
  logic             to_armed_s;
  logic             cnt_clr_s;
  logic             cyc_clr_s;
  logic             timeout_trig_s;

  logic [NCH-1:0]   trig_cap_r;
  logic             busy_r;
  logic             armed_r;
  logic             done_r;
  logic             done_pulse_r;
  logic             timed_out_r;
  logic [15:0]      cap_count_r;
  logic [2:0]       state_mon_r;

  // Next-state decode plus the counter/latch control strobes for this cycle.
  always_comb begin
    state_nxt_s    = state_r;
    latch_mask_s   = 1'b0;
    to_armed_s     = 1'b0;
    cnt_clr_s      = 1'b0;
    cyc_clr_s      = 1'b0;
    timeout_trig_s = 1'b0;

    ext_edge_s = ext_trig & ~ext_prev_r;
    tmo_hit_s  = (timeout_cyc != {CNT_W{1'b0}}) &&
                 (cnt_r == (timeout_cyc - CNT_W'(1)));
    hold_hit_s = (holdoff_cyc == {CNT_W{1'b0}}) ||
                 (cnt_r == (holdoff_cyc - CNT_W'(1)));
    // Reserved trigger modes behave as immediate.
    if (trig_mode == TRIG_MODE_EXT) begin
      trig_now_s = ext_edge_s;
    end else begin
      trig_now_s = 1'b1;
    end

    if (abort) begin
      state_nxt_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (arm) begin
            state_nxt_s  = ST_ARMED;
            latch_mask_s = 1'b1;
            to_armed_s   = 1'b1;
            cnt_clr_s    = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_ARMED: begin
          // A genuine trigger in the same cycle as the timeout is not a timeout.
          if (trig_now_s) begin
            state_nxt_s = ST_TRIG;
            cyc_clr_s   = 1'b1;
          end else if (tmo_hit_s) begin
            state_nxt_s    = ST_TRIG;
            cyc_clr_s      = 1'b1;
            timeout_trig_s = 1'b1;
          end else begin
            state_nxt_s = ST_ARMED;
          end
        end
        ST_TRIG: begin
          if (cyc_r == TRIG_LAST) begin
            state_nxt_s = ST_CAPTURE;
          end else begin
            state_nxt_s = ST_TRIG;
          end
        end
        ST_CAPTURE: begin
          if (cyc_r == CAP_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_CAPTURE;
          end
        end
        ST_DONE: begin
          if (repeat_en) begin
            state_nxt_s = ST_HOLDOFF;
            cnt_clr_s   = 1'b1;
          end else begin
            state_nxt_s = ST_IDLE;
          end
        end
        ST_HOLDOFF: begin
          if (hold_hit_s) begin
            state_nxt_s = ST_ARMED;
            to_armed_s  = 1'b1;
            cnt_clr_s   = 1'b1;
          end else begin
            state_nxt_s = ST_HOLDOFF;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register, channel mask latch, edge-detect history and cycle counters.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      state_r    <= ST_IDLE;
      mask_r     <= {NCH{1'b0}};
      cyc_r      <= {CYC_W{1'b0}};
      cnt_r      <= {CNT_W{1'b0}};
      ext_prev_r <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      ext_prev_r <= ext_trig;
      if (latch_mask_s) begin
        mask_r <= chan_mask;
      end
      if (cyc_clr_s) begin
        cyc_r <= {CYC_W{1'b0}};
      end else if ((state_r == ST_TRIG) || (state_r == ST_CAPTURE)) begin
        cyc_r <= cyc_r + CYC_W'(1);
      end
      // One counter serves both the ARMED timeout and the HOLDOFF wait.
      if (cnt_clr_s) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if ((state_r == ST_ARMED) || (state_r == ST_HOLDOFF)) begin
        cnt_r <= cnt_r + CNT_W'(1);
      end
    end
  end

  // Outputs are decoded from the next state so they align with the state they describe.
  always_ff @(posedge axis_clk) begin
    if (axis_rst) begin
      trig_cap_r   <= {NCH{1'b0}};
      busy_r       <= 1'b0;
      armed_r      <= 1'b0;
      done_r       <= 1'b0;
      done_pulse_r <= 1'b0;
      timed_out_r  <= 1'b0;
      cap_count_r  <= 16'd0;
      state_mon_r  <= 3'd0;
    end else begin
      trig_cap_r   <= (state_nxt_s == ST_TRIG) ? mask_r : {NCH{1'b0}};
      busy_r       <= (state_nxt_s != ST_IDLE);
      armed_r      <= (state_nxt_s == ST_ARMED);
      done_pulse_r <= (state_nxt_s == ST_DONE);
      state_mon_r  <= state_nxt_s;
      if (to_armed_s) begin
        done_r <= 1'b0;
      end else if (state_nxt_s == ST_DONE) begin
        done_r <= 1'b1;
      end
      if (to_armed_s) begin
        timed_out_r <= 1'b0;
      end else if (timeout_trig_s) begin
        timed_out_r <= 1'b1;
      end
      if (state_nxt_s == ST_DONE) begin
        cap_count_r <= cap_count_r + 16'd1;
      end
    end
  end

  assign trig_cap   = trig_cap_r;
  assign busy       = busy_r;
  assign armed      = armed_r;
  assign done       = done_r;
  assign done_pulse = done_pulse_r;
  assign timed_out  = timed_out_r;
  assign cap_count  = cap_count_r;
  assign state_mon  = state_mon_r;

endmodule

// File: tb/tb_snapshot_capture_sequencer.sv
// Directed bench for snapshot_capture_sequencer with a 16-beat capture
// (MEM_SIZE_BYTES=256, DWIDTH=128), TRIG_HOLD=4, SYNC_LAT=3.
module tb_snapshot_capture_sequencer;

  localparam int NCH   = 4;
  localparam int CNT_W = 32;

  logic             axis_clk = 1'b0;
  logic             axis_rst;
  logic             arm;
  logic             abort;
  logic [1:0]       trig_mode;
  logic [NCH-1:0]   chan_mask;
  logic             ext_trig;
  logic [CNT_W-1:0] timeout_cyc;
  logic             repeat_en;
  logic [CNT_W-1:0] holdoff_cyc;
  logic [NCH-1:0]   trig_cap;
  logic             busy;
  logic             armed;
  logic             done;
  logic             done_pulse;
  logic             timed_out;
  logic [15:0]      cap_count;
  logic [2:0]       state_mon;

  int total = 0;
  int bad   = 0;
  int cycle_n = 0;
  int t1;
  int t2;
  logic found;

  snapshot_capture_sequencer #(
    .NCH(NCH), .DWIDTH(128), .MEM_SIZE_BYTES(256),
    .TRIG_HOLD(4), .SYNC_LAT(3), .CNT_W(CNT_W)
  ) dut (
    .axis_clk(axis_clk), .axis_rst(axis_rst), .arm(arm), .abort(abort),
    .trig_mode(trig_mode), .chan_mask(chan_mask), .ext_trig(ext_trig),
    .timeout_cyc(timeout_cyc), .repeat_en(repeat_en), .holdoff_cyc(holdoff_cyc),
    .trig_cap(trig_cap), .busy(busy), .armed(armed), .done(done),
    .done_pulse(done_pulse), .timed_out(timed_out), .cap_count(cap_count),
    .state_mon(state_mon)
  );

  always #5 axis_clk = ~axis_clk;

  always @(posedge axis_clk) cycle_n <= cycle_n + 1;

  task automatic tick();
    @(posedge axis_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int bound, output int at, output logic hit);
    hit = 1'b0;
    at  = 0;
    for (int i = 0; i < bound; i++) begin
      if (done_pulse === 1'b1) begin
        hit = 1'b1;
        at  = cycle_n;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_idle(input int bound, output logic hit);
    hit = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (busy === 1'b0) begin
        hit = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    axis_rst = 1'b1; arm = 1'b0; abort = 1'b0; trig_mode = 2'd0;
    chan_mask = 4'b0000; ext_trig = 1'b0; timeout_cyc = 32'd0;
    repeat_en = 1'b0; holdoff_cyc = 32'd0;
    tick(); tick();
    chk("rst_trig_cap", 32'(trig_cap), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_armed", 32'(armed), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_done_pulse", 32'(done_pulse), 32'd0);
    chk("rst_timed_out", 32'(timed_out), 32'd0);
    chk("rst_cap_count", 32'(cap_count), 32'd0);
    chk("rst_state", 32'(state_mon), 32'd0);
    axis_rst = 1'b0;
    tick();

    // Immediate mode, mask 0101, arm in cycle t0.
    chan_mask = 4'b0101; arm = 1'b1;
    tick(); arm = 1'b0;                           // t0+1
    chk("m0_armed", 32'(armed), 32'd1);
    chk("m0_state_armed", 32'(state_mon), 32'd1);
    chk("m0_trig_pre", 32'(trig_cap), 32'd0);
    tick();                                       // t0+2
    for (int i = 0; i < 4; i++) begin
      chk("m0_trig_hold", 32'(trig_cap), 32'h5);
      chk("m0_state_trig", 32'(state_mon), 32'd2);
      tick();
    end                                           // t0+6
    chk("m0_trig_drop", 32'(trig_cap), 32'd0);
    chk("m0_state_cap", 32'(state_mon), 32'd3);
    repeat (14) tick();                           // t0+20
    chk("m0_no_early_done", 32'(done_pulse), 32'd0);
    tick();                                       // t0+21
    chk("m0_done_pulse", 32'(done_pulse), 32'd1);
    chk("m0_done", 32'(done), 32'd1);
    chk("m0_cap_count", 32'(cap_count), 32'd1);
    chk("m0_state_done", 32'(state_mon), 32'd4);
    tick();                                       // t0+22
    chk("m0_busy_low", 32'(busy), 32'd0);
    chk("m0_pulse_low", 32'(done_pulse), 32'd0);
    chk("m0_done_sticky", 32'(done), 32'd1);

    // External edge mode; ext_trig already high at arm must not fire.
    ext_trig = 1'b1; trig_mode = 2'd1; chan_mask = 4'b1111;
    tick();
    arm = 1'b1;
    tick(); arm = 1'b0;
    chk("m1_armed", 32'(armed), 32'd1);
    chk("m1_done_cleared", 32'(done), 32'd0);
    for (int i = 0; i < 48; i++) begin
      ext_trig = (i < 10) ? 1'b1 : 1'b0;
      tick();
    end
    chk("m1_held_no_fire", 32'(state_mon), 32'd1);
    chk("m1_trig_idle", 32'(trig_cap), 32'd0);
    ext_trig = 1'b1;
    tick();
    chk("m1_edge_trig", 32'(trig_cap), 32'hF);
    chk("m1_state_trig", 32'(state_mon), 32'd2);
    ext_trig = 1'b0;
    wait_idle(40, found);
    chk("m1_finish", 32'(found), 32'd1);
    chk("m1_cap_count", 32'(cap_count), 32'd2);
    chk("m1_not_timed_out", 32'(timed_out), 32'd0);

    // Timeout of 10 cycles with no external edge.
    timeout_cyc = 32'd10; chan_mask = 4'b0010; arm = 1'b1;
    tick(); arm = 1'b0;                           // first ARMED cycle
    repeat (9) tick();
    chk("to_still_armed", 32'(state_mon), 32'd1);
    chk("to_trig_low", 32'(trig_cap), 32'd0);
    tick();
    chk("to_trig", 32'(trig_cap), 32'h2);
    chk("to_timed_out", 32'(timed_out), 32'd1);
    wait_idle(40, found);
    chk("to_finish", 32'(found), 32'd1);
    chk("to_sticky", 32'(timed_out), 32'd1);
    chk("to_cap_count", 32'(cap_count), 32'd3);
    timeout_cyc = 32'd0; trig_mode = 2'd0; arm = 1'b1;
    tick(); arm = 1'b0;
    chk("to_cleared", 32'(timed_out), 32'd0);
    chk("to_done_cleared", 32'(done), 32'd0);
    wait_idle(40, found);
    chk("to2_finish", 32'(found), 32'd1);
    chk("to2_cap_count", 32'(cap_count), 32'd4);

    // Auto-repeat with holdoff 5: DONE+HOLDOFF(5)+ARMED+TRIG(4)+CAPTURE(15).
    repeat_en = 1'b1; holdoff_cyc = 32'd5; chan_mask = 4'b1000; arm = 1'b1;
    tick(); arm = 1'b0;
    wait_done(40, t1, found);
    chk("rp_first_done", 32'(found), 32'd1);
    chk("rp_count1", 32'(cap_count), 32'd5);
    tick();
    chk("rp_holdoff", 32'(state_mon), 32'd5);
    chk("rp_done_held", 32'(done), 32'd1);
    wait_done(40, t2, found);
    chk("rp_second_done", 32'(found), 32'd1);
    chk("rp_period", 32'(t2 - t1), 32'd26);
    chk("rp_count2", 32'(cap_count), 32'd6);
    tick();
    abort = 1'b1;
    tick(); abort = 1'b0; repeat_en = 1'b0;
    chk("rp_abort_idle", 32'(state_mon), 32'd0);
    chk("rp_abort_busy", 32'(busy), 32'd0);
    repeat (30) tick();
    chk("rp_stopped", 32'(state_mon), 32'd0);
    chk("rp_count_kept", 32'(cap_count), 32'd6);

    // Abort on the second TRIG cycle.
    chan_mask = 4'b0111; arm = 1'b1;
    tick(); arm = 1'b0;
    chk("ab_done_cleared", 32'(done), 32'd0);
    tick(); tick();
    chk("ab_trig_c2", 32'(trig_cap), 32'h7);
    abort = 1'b1;
    tick(); abort = 1'b0;
    chk("ab_trig_zero", 32'(trig_cap), 32'd0);
    chk("ab_idle", 32'(state_mon), 32'd0);
    chk("ab_no_done", 32'(done), 32'd0);
    chk("ab_count", 32'(cap_count), 32'd6);

    // Arm and abort together: abort wins.
    arm = 1'b1; abort = 1'b1;
    tick(); arm = 1'b0; abort = 1'b0;
    chk("aa_idle", 32'(state_mon), 32'd0);
    chk("aa_armed", 32'(armed), 32'd0);

    // Arm during CAPTURE is ignored; reset mid-CAPTURE clears all outputs.
    chan_mask = 4'b0001; arm = 1'b1;
    tick(); arm = 1'b0;
    repeat (5) tick();
    chk("bc_capture", 32'(state_mon), 32'd3);
    chan_mask = 4'b1111; arm = 1'b1;
    tick(); arm = 1'b0;
    chk("bc_ignored", 32'(state_mon), 32'd3);
    chk("bc_trig_low", 32'(trig_cap), 32'd0);
    axis_rst = 1'b1;
    tick();
    chk("mr_state", 32'(state_mon), 32'd0);
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_cap_count", 32'(cap_count), 32'd0);
    chk("mr_done", 32'(done), 32'd0);
    chk("mr_trig", 32'(trig_cap), 32'd0);
    axis_rst = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
